fib_seq_gen: RTL

Parametrised Fibonacci sequence engine, the successor to the fixed 6-bit `Fib` block. It takes two seed values and a term count and emits the sequence over a valid/ready stream. It detects overflow under a selectable policy and keeps the last DEPTH emitted terms in a readable history buffer. It sits between the lab control logic and any display or checking consumer.

---
 rtl/fib_pkg.sv | 7 +
 rtl/fib_seq_gen_if.sv | 28 ++
 rtl/fib_hist_buf.sv | 29 ++
 rtl/fib_seq_gen.sv | 78 +++++++
 4 files changed

// File: rtl/fib_pkg.sv
// fib_pkg: overflow policy codes and FSM state type shared by the Fibonacci engine
package fib_pkg;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
  localparam int MODE_STOP = 2;
  typedef enum logic [1:0] {IDLE, EMIT, DONE} fib_state_t;
endpackage

// File: rtl/fib_seq_gen_if.sv
// fib_seq_gen_if: control, output stream and history read port of the Fibonacci engine
interface fib_seq_gen_if #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8,
  parameter int CNTW = 8
);
  logic start;
  logic [WIDTH-1:0] seed0;
  logic [WIDTH-1:0] seed1;
  logic [CNTW-1:0] count;
  logic busy;
  logic done;
  logic overflow;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  logic [$clog2(DEPTH)-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [$clog2(DEPTH):0] hist_cnt;
  modport master (
    output start, seed0, seed1, count, out_ready, rd_addr,
    input busy, done, overflow, out_valid, out_data, rd_data, hist_cnt
  );
  modport slave (
    input start, seed0, seed1, count, out_ready, rd_addr,
    output busy, done, overflow, out_valid, out_data, rd_data, hist_cnt
  );
endinterface

// File: rtl/fib_hist_buf.sv
// fib_hist_buf: ring of the last DEPTH emitted terms with saturating fill count
module fib_hist_buf #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  input logic we,
  input logic [WIDTH-1:0] wdata,
  input logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [$clog2(DEPTH):0] hist_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  assign rd_data = mem[rd_addr];
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
      wr_ptr <= '0;
      hist_cnt <= '0;
    end else if (we) begin
      mem[wr_ptr] <= wdata;
      wr_ptr <= wr_ptr + 1'b1;
      if (hist_cnt != (AW+1)'(DEPTH)) hist_cnt <= hist_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/fib_seq_gen.sv
// fib_seq_gen: seeded Fibonacci stream with WRAP/SAT/STOP overflow handling and term history
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8,
  parameter int CNTW = 8,
  parameter int MODE = MODE_WRAP
) (
  input logic clk,
  input logic rst,
  fib_seq_gen_if.slave bus
);
  fib_state_t state, state_n;
  logic [WIDTH-1:0] a, b, nxt;
  logic [WIDTH:0] sum;
  logic a_ovf, b_ovf, ovf, blocked, hs;
  logic [CNTW-1:0] remaining;
  assign sum = {1'b0, a} + {1'b0, b};
  assign nxt = (MODE == MODE_SAT && (sum[WIDTH] || b_ovf)) ? '1 : sum[WIDTH-1:0];
  // under STOP a term born from a carry is withheld and ends the run
  assign blocked = state == EMIT && MODE == MODE_STOP && a_ovf;
  assign bus.out_valid = state == EMIT && !blocked;
  assign hs = bus.out_valid && bus.out_ready;
  assign bus.out_data = a;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.overflow = ovf;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (bus.start ? ((bus.count == '0) ? DONE : EMIT) : IDLE)
            : (state == EMIT) ? ((blocked || (hs && remaining == CNTW'(1))) ? DONE : EMIT)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      a_ovf <= 1'b0;
      b_ovf <= 1'b0;
      remaining <= '0;
      ovf <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        ovf <= 1'b0;
        if (bus.count != '0) begin
          a <= bus.seed0;
          b <= bus.seed1;
          a_ovf <= 1'b0;
          b_ovf <= 1'b0;
          remaining <= bus.count;
        end
      end
      if (hs) begin
        a <= b;
        a_ovf <= b_ovf;
        b <= nxt;
        b_ovf <= MODE == MODE_STOP && sum[WIDTH];
        remaining <= remaining - 1'b1;
        if (MODE != MODE_STOP && sum[WIDTH]) ovf <= 1'b1;
      end
      if (blocked) ovf <= 1'b1;
    end
  end
  fib_hist_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) hist (
    .clk(clk),
    .rst(rst),
    .we(hs),
    .wdata(a),
    .rd_addr(bus.rd_addr),
    .rd_data(bus.rd_data),
    .hist_cnt(bus.hist_cnt)
  );
endmodule
